// File: rtl/srmem_single_feeder_if.sv
// Feeder-side bus of a single-bank srmem: upstream PCH-info stream plus the
// controller's serial fill interface and its phase-status inputs.
interface srmem_single_feeder_if #(
   parameter int DATA_BW = 8
);
   // upstream valid/ready stream
   logic               src_valid;
   logic [DATA_BW-1:0] src_data;
   logic               src_ready;
   // srmem controller fill interface and status
   logic               wrfull;
   logic               wrend;
   logic               rdend;
   logic               valid_din;
   logic [DATA_BW-1:0] din;
   logic               is_lastdin;

   // feeder side
   modport master (
      input  src_valid, src_data, wrfull, wrend, rdend,
      output src_ready, valid_din, din, is_lastdin
   );

   // environment side: upstream source plus srmem controller
   modport slave (
      output src_valid, src_data, wrfull, wrend, rdend,
      input  src_ready, valid_din, din, is_lastdin
   );
endinterface

// File: rtl/srmem_single_feeder.sv
// Write-side producer for one single-bank srmem controller. Streams one batch
// of PCH-info entries into the controller's serial fill port, flags the final
// entry, then waits for the reader to drain the batch before taking a new start.
module srmem_single_feeder #(
   parameter  int NUM_RDPORT = 4,
   parameter  int LEN_SRMEM  = 4,
   parameter  int DATA_BW    = 8,
   localparam int NUM_ENTRY  = NUM_RDPORT * LEN_SRMEM,
   localparam int CNT_BW     = $clog2(NUM_ENTRY) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [CNT_BW-1:0]        num_entry,
   srmem_single_feeder_if.master    bus,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   localparam logic [CNT_BW-1:0] MAX_LEN = CNT_BW'(NUM_ENTRY);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      STREAM  = 2'd1,
      WAIT_RD = 2'd2
   } state_t;

   state_t            state;
   logic [CNT_BW-1:0] len;   // batch length after clamping
   logic [CNT_BW-1:0] cnt;   // entries taken from upstream so far

   logic hs;        // upstream handshake this cycle
   logic accept;    // controller consumes the registered entry
   logic last_acc;  // controller consumes the final entry of the batch

   // Upstream may only push when the output register frees up this cycle and
   // the batch still has entries outstanding.
   assign bus.src_ready = (state == STREAM) && (cnt < len) &&
                          (!bus.valid_din || !bus.wrfull);
   assign hs       = bus.src_valid && bus.src_ready;
   assign accept   = bus.valid_din && !bus.wrfull;
   assign last_acc = accept && bus.is_lastdin;
   assign busy     = (state != IDLE);

   // Batch FSM, one-entry output register and sticky protocol-error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         len            <= '0;
         cnt            <= '0;
         bus.valid_din  <= 1'b0;
         bus.din        <= '0;
         bus.is_lastdin <= 1'b0;
         done           <= 1'b0;
         err            <= 1'b0;
      end else begin
         done <= 1'b0;

         // Fill-end must coincide exactly with acceptance of the last entry;
         // read-end is meaningless while still streaming.
         if ((bus.wrend && !last_acc) ||
             (last_acc && !bus.wrend) ||
             (bus.rdend && state == STREAM))
            err <= 1'b1;

         case (state)
            IDLE: begin
               // zero-length requests are dropped, oversize ones clamped
               if (start && num_entry != '0) begin
                  len   <= (num_entry > MAX_LEN) ? MAX_LEN : num_entry;
                  cnt   <= '0;
                  state <= STREAM;
               end
            end

            STREAM: begin
               if (hs) begin
                  bus.valid_din  <= 1'b1;
                  bus.din        <= bus.src_data;
                  bus.is_lastdin <= (cnt == len - CNT_BW'(1));
                  cnt            <= cnt + CNT_BW'(1);
               end else if (accept) begin
                  bus.valid_din  <= 1'b0;
               end
               // cnt==len once the last entry is registered, so no handshake
               // can collide with its acceptance
               if (last_acc) begin
                  bus.valid_din  <= 1'b0;
                  bus.is_lastdin <= 1'b0;
                  state          <= WAIT_RD;
               end
            end

            WAIT_RD: begin
               if (bus.rdend) begin
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_srmem_single_feeder.sv
// Randomised bench for srmem_single_feeder. A queue-based scoreboard tracks
// entries taken from upstream and expects them on the fill port in order,
// one cycle later, with the batch-length and error rules applied at the
// transaction level.
module tb_srmem_single_feeder;

   localparam int NE = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [4:0] num_entry = '0;
   logic       busy, done, err;

   srmem_single_feeder_if #(.DATA_BW(8)) bus ();

   srmem_single_feeder #(.NUM_RDPORT(4), .LEN_SRMEM(4), .DATA_BW(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .num_entry (num_entry),
      .bus       (bus),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // stimulus knobs
   int         sv_pct, wf_pct, st_pct;
   int         hold_val = -1, wrend_at = -1, rd_inj_at = -1;
   bit         seq_data;
   bit         inj_start, inj_rdend;
   logic [4:0] inj_num;

   // reference model
   logic [7:0] q[$];
   int         exp_len, hs_cnt, out_cnt, hold_cnt;
   bit         in_stream, busy_m, done_exp, err_exp, err_pend, hold_prev;
   logic [7:0] prev_din, next_data, last_din;
   logic       prev_last;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Checks taken once per cycle on the falling edge.
   task automatic monitor();
      logic [7:0] e;
      chk("vld", 32'(bus.valid_din), 32'(q.size() != 0));
      chk("rdy", 32'(bus.src_ready),
          32'(in_stream && hs_cnt < exp_len && !(bus.valid_din && bus.wrfull)));
      chk("busy", 32'(busy), 32'(busy_m));
      chk("done", 32'(done), 32'(done_exp));
      done_exp = 1'b0;
      chk("err", 32'(err), 32'(err_exp));
      if (hold_prev) begin
         chk("hold_vld", 32'(bus.valid_din), 32'd1);
         chk("hold_din", 32'(bus.din), 32'(prev_din));
         chk("hold_last", 32'(bus.is_lastdin), 32'(prev_last));
      end
      hold_prev = bus.valid_din && bus.wrfull;
      prev_din  = bus.din;
      prev_last = bus.is_lastdin;
      if (bus.valid_din && !bus.wrfull && q.size() != 0) begin
         e = q.pop_front();
         chk("din", 32'(bus.din), 32'(e));
         chk("last", 32'(bus.is_lastdin), 32'(out_cnt == exp_len - 1));
         last_din = bus.din;
         out_cnt++;
         if (out_cnt == exp_len) in_stream = 1'b0;
      end
      if (bus.src_valid && bus.src_ready) begin
         q.push_back(bus.src_data);
         hs_cnt++;
         next_data++;
      end
   endtask

   // One clock: drive inputs just after the rising edge, check on the falling edge.
   task automatic cycle();
      @(posedge clk);
      #1;
      if (err_pend) begin
         err_exp  = 1'b1;
         err_pend = 1'b0;
      end
      bus.src_valid = ($urandom_range(99) < sv_pct);
      bus.src_data  = seq_data ? next_data : 8'($urandom);
      bus.wrfull    = ($urandom_range(99) < wf_pct);
      if (hold_val >= 0 && bus.valid_din && bus.din == 8'(hold_val) && hold_cnt < 3) begin
         bus.wrfull = 1'b1;
         hold_cnt++;
      end
      // well-behaved controller: fill ends exactly when the last entry is taken
      bus.wrend = bus.valid_din & bus.is_lastdin & ~bus.wrfull;
      if (wrend_at >= 0 && bus.valid_din && !bus.is_lastdin && bus.din == 8'(wrend_at))
         bus.wrend = 1'b1;
      bus.rdend = inj_rdend;
      start     = inj_start;
      num_entry = inj_num;
      if (bus.wrend && !(bus.valid_din && bus.is_lastdin && !bus.wrfull)) err_pend = 1'b1;
      if (bus.rdend && in_stream) err_pend = 1'b1;
      @(negedge clk);
      monitor();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1; start = 1'b0;
      bus.src_valid = 1'b0; bus.wrfull = 1'b0; bus.wrend = 1'b0; bus.rdend = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_rdy",  32'(bus.src_ready), 32'd0);
      chk("rst_vld",  32'(bus.valid_din), 32'd0);
      chk("rst_din",  32'(bus.din), 32'd0);
      chk("rst_last", 32'(bus.is_lastdin), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err",  32'(err), 32'd0);
      q.delete();
      in_stream = 0; busy_m = 0; done_exp = 0; err_exp = 0; err_pend = 0;
      hold_prev = 0; exp_len = 0;
   endtask

   task automatic knobs(input int sv, input int wf, input int st, input bit sq);
      sv_pct = sv; wf_pct = wf; st_pct = st; seq_data = sq;
      hold_val = -1; wrend_at = -1; rd_inj_at = -1;
      inj_start = 0; inj_rdend = 0; inj_num = '0;
   endtask

   // One batch of n requested entries; abort>=0 returns after that many
   // entries reach the controller, leaving the batch unfinished.
   task automatic run_batch(input int n, input int abort);
      if (seq_data) next_data = '0;
      hold_cnt  = 0;
      inj_start = 1'b1;
      inj_num   = 5'(n);
      cycle();
      inj_start = 1'b0;
      exp_len   = (n == 0) ? 0 : ((n > NE) ? NE : n);
      if (exp_len == 0) begin
         cycle();
         chk("zero_busy", 32'(busy), 32'd0);
         return;
      end
      in_stream = 1; busy_m = 1; hs_cnt = 0; out_cnt = 0;
      for (int i = 0; i < 600 && in_stream; i++) begin
         inj_start = ($urandom_range(99) < st_pct);
         inj_num   = 5'($urandom_range(1, 20));
         inj_rdend = (rd_inj_at >= 0 && out_cnt == rd_inj_at);
         cycle();
         inj_rdend = 1'b0;
         if (abort >= 0 && out_cnt >= abort) begin
            inj_start = 1'b0;
            return;
         end
      end
      inj_start = 1'b0;
      chk("len_out", 32'(out_cnt), 32'(exp_len));
      chk("len_hs", 32'(hs_cnt), 32'(exp_len));
      if (in_stream) begin
         in_stream = 1'b0;
         q.delete();
      end
      repeat ($urandom_range(1, 3)) begin
         inj_start = (st_pct > 0);
         cycle();
      end
      // read side drains; a start in the same cycle must be dropped
      inj_rdend = 1'b1;
      inj_start = (st_pct > 0);
      cycle();
      inj_rdend = 1'b0;
      inj_start = 1'b0;
      busy_m    = 1'b0;
      done_exp  = 1'b1;
      cycle();
      cycle();
   endtask

   initial begin
      bus.src_valid = 1'b0; bus.src_data = '0; bus.wrfull = 1'b0;
      bus.wrend = 1'b0; bus.rdend = 1'b0;
      knobs(100, 0, 0, 1'b0);
      do_reset();

      // full-length batch at full rate
      knobs(100, 0, 0, 1'b1);
      run_batch(16, -1);
      chk("t1_last", 32'(last_din), 32'h0F);

      // backpressure while the third entry is registered
      knobs(100, 0, 0, 1'b1);
      hold_val = 2;
      run_batch(5, -1);
      chk("t2_hold", 32'(hold_cnt), 32'd3);
      chk("t2_last", 32'(last_din), 32'h04);

      // length boundaries
      knobs(100, 0, 0, 1'b1);
      run_batch(1, -1);
      chk("t3_one", 32'(last_din), 32'h00);
      run_batch(0, -1);
      run_batch(20, -1);
      chk("t3_clamp", 32'(last_din), 32'h0F);

      // stray starts during STREAM / WAIT_RD / with rdend
      knobs(80, 20, 50, 1'b1);
      run_batch(6, -1);
      chk("t4_last", 32'(last_din), 32'h05);

      // reset mid-batch, then a fresh short batch
      knobs(100, 0, 0, 1'b1);
      run_batch(16, 7);
      do_reset();
      run_batch(2, -1);
      chk("t5_last", 32'(last_din), 32'h01);

      // premature wrend, sticky error
      knobs(100, 0, 0, 1'b1);
      wrend_at = 2;
      run_batch(5, -1);
      wrend_at = -1;
      repeat (3) cycle();
      chk("t6_sticky", 32'(err), 32'd1);
      do_reset();

      // rdend while streaming
      knobs(100, 0, 0, 1'b1);
      rd_inj_at = 2;
      run_batch(4, -1);
      chk("t6_rdend", 32'(err), 32'd1);
      do_reset();

      // random traffic
      for (int b = 0; b < 25; b++) begin
         knobs($urandom_range(30, 100), $urandom_range(0, 50),
               ($urandom_range(1) != 0) ? 20 : 0, $urandom_range(1) != 0);
         run_batch($urandom_range(0, 20), -1);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
